// File: rtl/cp0_unit.sv
// MIPS-style coprocessor-0 subset: SR, Cause and EPC with exception/interrupt entry and eret.
// Optional macro CP0_PRID_EN adds a read-only PRId register at address 15.
module cp0_unit #(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_in,
    output logic [31:0] cp0_out,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        exl_clr,
    output logic        req,
    output logic [31:0] epc_out,
    output logic [31:0] handler_pc
);

    localparam logic [4:0]  ADDR_SR    = 5'd12;
    localparam logic [4:0]  ADDR_CAUSE = 5'd13;
    localparam logic [4:0]  ADDR_EPC   = 5'd14;
    localparam logic [4:0]  ADDR_PRID  = 5'd15;
    localparam logic [31:0] PRID_VALUE = 32'h2024_0001;

    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exc_code;
    logic [31:0] r_epc;

    logic [5:0]  w_im_nxt;
    logic        w_exl_nxt;
    logic        w_ie_nxt;
    logic        w_bd_nxt;
    logic [4:0]  w_exc_code_nxt;
    logic [31:0] w_epc_nxt;

    logic        w_int_req;
    logic        w_exc_req;
    logic        w_req;
    logic [31:0] w_sr;
    logic [31:0] w_cause;
    logic        w_unused_cp0_in;

    // EXL masks both sources so a handler is never re-entered before eret.
    assign w_int_req = (|(hw_int & r_im)) & r_ie & ~r_exl;
    assign w_exc_req = (exc_code_in != 5'd0) & ~r_exl;
    assign w_req     = w_int_req | w_exc_req;

    assign req        = w_req;
    assign epc_out    = r_epc;
    assign handler_pc = HANDLER_PC;

    assign w_sr    = {16'h0000, r_im, 8'h00, r_exl, r_ie};
    assign w_cause = {r_bd, 15'h0000, r_ip, 3'b000, r_exc_code, 2'b00};

    assign w_unused_cp0_in = ^{cp0_in[31:16], cp0_in[9:2]};

    // Next-state selection: exception entry beats eret, which in turn yields to an mtc0 SR write.
    always_comb begin
        w_im_nxt       = r_im;
        w_exl_nxt      = r_exl;
        w_ie_nxt       = r_ie;
        w_bd_nxt       = r_bd;
        w_exc_code_nxt = r_exc_code;
        w_epc_nxt      = r_epc;
        if (w_req) begin
            w_exl_nxt      = 1'b1;
            w_bd_nxt       = bd_in;
            w_exc_code_nxt = w_int_req ? 5'd0 : exc_code_in;
            w_epc_nxt      = bd_in ? (vpc - 32'd4) : vpc;
        end else begin
            if (exl_clr) begin
                w_exl_nxt = 1'b0;
            end else begin
                w_exl_nxt = r_exl;
            end
            if (en) begin
                case (cp0_addr)
                    ADDR_SR: begin
                        w_im_nxt  = cp0_in[15:10];
                        w_exl_nxt = cp0_in[1];
                        w_ie_nxt  = cp0_in[0];
                    end
                    ADDR_EPC: begin
                        w_epc_nxt = cp0_in;
                    end
                    default: begin
                        w_epc_nxt = r_epc;
                    end
                endcase
            end else begin
                w_epc_nxt = r_epc;
            end
        end
    end

    // State registers; IP tracks the interrupt lines every cycle outside reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_im       <= 6'd0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_ip       <= 6'd0;
            r_exc_code <= 5'd0;
            r_epc      <= 32'd0;
        end else begin
            r_im       <= w_im_nxt;
            r_exl      <= w_exl_nxt;
            r_ie       <= w_ie_nxt;
            r_bd       <= w_bd_nxt;
            r_ip       <= hw_int;
            r_exc_code <= w_exc_code_nxt;
            r_epc      <= w_epc_nxt;
        end
    end

    // mfc0 read mux.
    always_comb begin
        cp0_out = 32'd0;
        case (cp0_addr)
            ADDR_SR:    cp0_out = w_sr;
            ADDR_CAUSE: cp0_out = w_cause;
            ADDR_EPC:   cp0_out = r_epc;
`ifdef CP0_PRID_EN
            ADDR_PRID:  cp0_out = PRID_VALUE;
`else
            ADDR_PRID:  cp0_out = 32'd0;
`endif
            default:    cp0_out = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: stimulus queues expectations, a monitor process pops and compares them.
module tb_cp0_unit;

    localparam int K_REG = 0;
    localparam int K_REQ = 1;
    localparam int K_EPC = 2;
    localparam int K_HPC = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_in;
    logic [31:0] cp0_out;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        exl_clr;
    logic        req;
    logic [31:0] epc_out;
    logic [31:0] handler_pc;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    event sample_ev;
    int   n_vec = 0;
    int   n_err = 0;

    cp0_unit dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .cp0_addr   (cp0_addr),
        .cp0_in     (cp0_in),
        .cp0_out    (cp0_out),
        .vpc        (vpc),
        .bd_in      (bd_in),
        .exc_code_in(exc_code_in),
        .hw_int     (hw_int),
        .exl_clr    (exl_clr),
        .req        (req),
        .epc_out    (epc_out),
        .handler_pc (handler_pc)
    );

    always #10 clk = ~clk;

    // Monitor: drains every queued expectation when the stimulus marks the outputs as settled.
    initial begin
        forever begin
            @(sample_ev);
            while (sb_q.size() > 0) begin
                exp_t        e;
                logic [31:0] act;
                e = sb_q.pop_front();
                case (e.kind)
                    K_REG:   act = cp0_out;
                    K_REQ:   act = {31'd0, req};
                    K_EPC:   act = epc_out;
                    default: act = handler_pc;
                endcase
                n_vec++;
                if (act !== e.exp) begin
                    n_err++;
                    $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int kind, input string nm, input logic [31:0] exp);
        exp_t e;
        e.name = nm;
        e.kind = kind;
        e.exp  = exp;
        sb_q.push_back(e);
        -> sample_ev;
        #1;
    endtask

    task automatic exp_reg(input logic [4:0] a, input string nm, input logic [31:0] exp);
        cp0_addr = a;
        #1;
        push_exp(K_REG, nm, exp);
    endtask

    task automatic exp_sig(input int kind, input string nm, input logic [31:0] exp);
        #1;
        push_exp(kind, nm, exp);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        en       = 1'b1;
        cp0_addr = a;
        cp0_in   = d;
        tick();
        en       = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; cp0_addr = 5'd0; cp0_in = 32'd0;
        vpc = 32'd0; bd_in = 1'b0; exc_code_in = 5'd0; hw_int = 6'd0; exl_clr = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        exp_reg(5'd12, "rst_sr", 32'h0000_0000);
        exp_reg(5'd13, "rst_cause", 32'h0000_0000);
        exp_reg(5'd14, "rst_epc", 32'h0000_0000);
        exp_sig(K_REQ, "rst_req", 32'd0);
        exp_sig(K_EPC, "rst_epc_out", 32'd0);
        exp_sig(K_HPC, "handler_pc", 32'h0000_4180);

        // Interrupt entry
        mtc0(5'd12, 32'h0000_FC01);
        exp_reg(5'd12, "sr_write", 32'h0000_FC01);
        hw_int = 6'b000100; vpc = 32'h0000_3010; bd_in = 1'b0;
        exp_sig(K_REQ, "int_req_same_cycle", 32'd1);
        tick();
        exp_reg(5'd13, "int_cause", 32'h0000_1000);
        exp_reg(5'd14, "int_epc", 32'h0000_3010);
        exp_reg(5'd12, "int_sr_exl", 32'h0000_FC03);
        exp_sig(K_REQ, "int_req_masked_by_exl", 32'd0);
        exp_sig(K_EPC, "int_epc_out", 32'h0000_3010);

        // eret, then mask interrupts for the exception test
        hw_int = 6'd0; exl_clr = 1'b1;
        tick();
        exl_clr = 1'b0;
        exp_reg(5'd12, "eret_sr", 32'h0000_FC01);
        mtc0(5'd12, 32'h0000_FC00);

        // Overflow in a delay slot
        exc_code_in = 5'd12; vpc = 32'h0000_3020; bd_in = 1'b1;
        exp_sig(K_REQ, "ov_req", 32'd1);
        tick();
        exc_code_in = 5'd0;
        exp_reg(5'd14, "ov_epc_bd", 32'h0000_301C);
        exp_reg(5'd13, "ov_cause", 32'h8000_0030);
        exp_reg(5'd12, "ov_sr", 32'h0000_FC02);

        // No nesting while EXL=1, then eret releases the pending requests
        mtc0(5'd12, 32'h0000_FC03);
        exc_code_in = 5'd4; hw_int = 6'b000001;
        exp_sig(K_REQ, "exl_blocks_req", 32'd0);
        tick();
        exp_reg(5'd14, "exl_epc_kept", 32'h0000_301C);
        exl_clr = 1'b1;
        tick();
        exl_clr = 1'b0;
        exp_reg(5'd12, "exl_cleared", 32'h0000_FC01);
        exp_sig(K_REQ, "req_after_eret", 32'd1);
        exp_reg(5'd13, "cause_ip_live", 32'h8000_0430);
        bd_in = 1'b0; vpc = 32'h0000_3030;
        tick();
        exp_reg(5'd13, "int_beats_exc", 32'h0000_0400);
        exp_reg(5'd14, "int_beats_exc_epc", 32'h0000_3030);

        // mtc0 EPC collides with an exception: exception wins
        hw_int = 6'd0; exc_code_in = 5'd0; exl_clr = 1'b1;
        tick();
        exl_clr = 1'b0;
        en = 1'b1; cp0_addr = 5'd14; cp0_in = 32'hDEAD_BEEF;
        exc_code_in = 5'd5; vpc = 32'h0000_3040; bd_in = 1'b0;
        exp_sig(K_REQ, "ades_req", 32'd1);
        tick();
        en = 1'b0; exc_code_in = 5'd0;
        exp_reg(5'd14, "mtc0_discarded", 32'h0000_3040);
        exp_sig(K_EPC, "mtc0_discarded_out", 32'h0000_3040);
        exp_reg(5'd13, "ades_cause", 32'h0000_0014);

        // Plain writes: EPC writable, Cause read-only, SR masked to IM/EXL/IE
        exl_clr = 1'b1;
        tick();
        exl_clr = 1'b0;
        mtc0(5'd14, 32'hDEAD_BEEF);
        exp_sig(K_EPC, "epc_write", 32'hDEAD_BEEF);
        mtc0(5'd13, 32'hFFFF_FFFF);
        exp_reg(5'd13, "cause_ro", 32'h0000_0014);
        mtc0(5'd12, 32'hFFFF_FFFF);
        exp_reg(5'd12, "sr_mask", 32'h0000_FC03);
        mtc0(5'd12, 32'h0000_FC01);

        // eret coincident with an interrupt: EXL stays set
        hw_int = 6'b000010; exl_clr = 1'b1; vpc = 32'h0000_3050; bd_in = 1'b0;
        exp_sig(K_REQ, "clr_int_req", 32'd1);
        tick();
        exl_clr = 1'b0; hw_int = 6'd0;
        exp_reg(5'd12, "clr_vs_req_sr", 32'h0000_FC03);
        exp_reg(5'd14, "clr_vs_req_epc", 32'h0000_3050);

        // Unimplemented / optional registers
`ifdef CP0_PRID_EN
        exp_reg(5'd15, "prid", 32'h2024_0001);
`else
        exp_reg(5'd15, "prid", 32'h0000_0000);
`endif
        exp_reg(5'd3, "unimpl", 32'h0000_0000);

        // Reset mid-handler overrides IP sampling, EXL and EPC
        reset = 1'b1; hw_int = 6'b111111;
        tick();
        reset = 1'b0;
        exp_reg(5'd12, "midrst_sr", 32'h0000_0000);
        exp_reg(5'd13, "midrst_cause", 32'h0000_0000);
        exp_sig(K_EPC, "midrst_epc", 32'h0000_0000);
        exp_sig(K_REQ, "midrst_req", 32'd0);
        tick();
        exp_reg(5'd13, "ip_after_rst", 32'h0000_FC00);

        // EPC wrap-around for a delay slot at address 0
        exc_code_in = 5'd10; vpc = 32'h0000_0000; bd_in = 1'b1;
        exp_sig(K_REQ, "ri_req", 32'd1);
        tick();
        exc_code_in = 5'd0;
        exp_reg(5'd14, "epc_wrap", 32'hFFFF_FFFC);
        exp_reg(5'd13, "ri_cause", 32'h8000_FC28);

        #2;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cp0_unit.md
CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 The block SHALL have parameter HANDLER_PC, default 32'h0000_4180, the exception entry address presented on handler_pc.
REQ-002 The block SHALL have port clk, input, 1, the sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous, active-high.
REQ-004 The block SHALL have port en, input, 1, mtc0 write strobe.
REQ-005 The block SHALL have port cp0_addr, input, 5, register number for mtc0 write and mfc0 read.
REQ-006 The block SHALL have port cp0_in, input, 32, mtc0 write data.
REQ-007 The block SHALL have port cp0_out, output, 32, mfc0 read data.
REQ-008 The block SHALL have port vpc, input, 32, PC of the victim instruction in the exception stage.
REQ-009 The block SHALL have port bd_in, input, 1, victim is in a branch delay slot.
REQ-010 The block SHALL have port exc_code_in, input, 5, synchronous exception code (0 none; 4 AdEL, 5 AdES, 10 RI, 12 Ov, 8 Syscall).
REQ-011 The block SHALL have port hw_int, input, 6, level-sensitive hardware interrupt lines.
REQ-012 The block SHALL have port exl_clr, input, 1, eret commit.
REQ-013 The block SHALL have port req, output, 1, flush pipeline and redirect fetch.
REQ-014 The block SHALL have port epc_out, output, 32, current EPC, the eret target.
REQ-015 The block SHALL have port handler_pc, output, 32, HANDLER_PC constant.

Function
REQ-016 The block SHALL implement SR (reg 12: IM[15:10], EXL[1], IE[0], all other bits read 0), Cause (reg 13: BD[31], IP[15:10], ExcCode[6:2], all other bits read 0) and EPC (reg 14, 32 bits).
REQ-017 The block SHALL drive int_req = |(hw_int & SR.IM) & SR.IE & ~SR.EXL and exc_req = (exc_code_in != 0) & ~SR.EXL, combinationally.
REQ-018 The block SHALL drive req = int_req | exc_req combinationally in the same cycle (zero latency); req is never registered.
REQ-019 On a clock edge with req=1, the block SHALL set EXL<=1, Cause.BD<=bd_in, ExcCode<=(int_req ? 0 : exc_code_in), and EPC<=(bd_in ? vpc-4 : vpc) using 32-bit wrap-around subtraction; the interrupt takes priority over a simultaneous exception.
REQ-020 Every cycle not in reset, the block SHALL load Cause.IP<=hw_int regardless of EXL and of req.
REQ-021 On a clock edge with exl_clr=1 and req=0, the block SHALL clear EXL; with req=1 on the same edge, EXL SHALL be 1.
REQ-022 With en=1, req=0, the block SHALL write SR (bits IM, EXL, IE only) when cp0_addr=12 and EPC (all 32 bits) when cp0_addr=14; Cause and all other addresses SHALL ignore writes.
REQ-023 With en=1 and req=1 on the same edge, the req updates SHALL win and the mtc0 write SHALL be discarded entirely.
REQ-024 The block SHALL drive cp0_out combinationally from cp0_addr, returning current register contents and 0 for any unimplemented address.
REQ-025 The block SHALL drive epc_out with the registered EPC value; writes become visible on it the cycle after the edge.
REQ-026 While EXL=1, the block SHALL keep req at 0 (no nesting), even with pending interrupts or a nonzero exc_code_in.

Reset
REQ-027 On a clock edge with reset=1, the block SHALL clear SR, Cause and EPC to 0, overriding req, en and exl_clr; req and cp0_out SHALL therefore settle to values derived from zeroed registers in the following cycle.
REQ-028 When reset asserts mid-handler with EXL=1, the block SHALL clear EXL and discard EPC.

Configuration
REQ-029 With macro CP0_PRID_EN defined, the block SHALL implement read-only PRId (reg 15) returning 32'h2024_0001, with writes ignored; without the macro, address 15 SHALL read 0 like any unimplemented register.

Verification
REQ-030 The bench SHALL check: after reset, write SR=32'h0000_FC01; set hw_int=6'b000100, vpc=32'h0000_3010, bd_in=0 -> req=1 the same cycle; after the edge EXL=1, ExcCode=0, EPC=32'h0000_3010, Cause=32'h0000_1000.
REQ-031 The bench SHALL check: with IE=0, apply exc_code_in=12, vpc=32'h0000_3020, bd_in=1 -> req=1; after the edge EPC=32'h0000_301C, Cause=32'h8000_0030.
REQ-032 The bench SHALL check: with EXL=1, apply exc_code_in=4 and unmasked hw_int -> req=0 and EPC unchanged; then pulse exl_clr -> EXL=0 and req=1 the next cycle.
REQ-033 The bench SHALL check: on one edge apply en=1, cp0_addr=14, cp0_in=32'hDEAD_BEEF together with exc_code_in=5, vpc=32'h0000_3040 -> EPC=32'h0000_3040.
REQ-034 The bench SHALL check: on one edge apply exl_clr=1 together with an enabled interrupt while EXL=0 -> EXL=1 afterwards.
REQ-035 The bench SHALL check: read cp0_addr=15 -> 32'h2024_0001 with CP0_PRID_EN defined, 0 without it; read cp0_addr=3 -> 0.
